priority_request_encoder: RTL and testbench

- Registered 32-to-5 priority encoder with request latching and a valid/ack handshake.
- Collects up to 32 request lines into a pending register and presents the binary index of the highest-priority unmasked pending request.
- Clears that request on acknowledge.
- Sits between per-source request lines (interrupt/exception sources, writeback requesters) and the control unit that consumes a 5-bit index.

---
 rtl/priority_request_encoder_if.sv | 23 ++
 rtl/priority_request_encoder.sv | 99 +++++++++
 tb/tb_priority_request_encoder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_request_encoder_if.sv
// Request/ack bundle between request sources, the encoder and its consumer.
// slave: encoder side (takes request/mask/flush/ack, drives index/valid/grant/pending).
interface priority_request_encoder_if;
    logic [31:0] request;
    logic [31:0] mask;
    logic        flush;
    logic        ack;
    logic [4:0]  index;
    logic        valid;
    logic [31:0] grant;
    logic [31:0] pending;
    logic        any_pending;

    modport master (
        output request, mask, flush, ack,
        input  index, valid, grant, pending, any_pending
    );

    modport slave (
        input  request, mask, flush, ack,
        output index, valid, grant, pending, any_pending
    );
endinterface

// File: rtl/priority_request_encoder.sv
// Registered 32-to-5 priority encoder with request latching and valid/ack.
// Ports: clock, reset_n (sync, active-low), bus (slave modport of the _if).
module priority_request_encoder #(
    parameter bit LSB_PRIORITY = 1'b1
) (
    input logic clock,
    input logic reset_n,
    priority_request_encoder_if.slave bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t      state;
    logic [31:0] pend_q;
    logic [31:0] grant_q;
    logic [4:0]  index_q;
    logic        valid_q;

    logic [31:0] clr;
    logic [31:0] nxt_pend;
    logic [31:0] cand;
    logic [4:0]  enc_idx;
    logic        cand_any;

    // Set term is OR-ed after the clear, so a same-cycle request wins.
    always_comb begin
        clr = '0;
        if (state == PRESENT && bus.ack) begin
            clr = 32'h1 << index_q;
        end
        nxt_pend = (pend_q & ~clr) | bus.request;
        cand     = nxt_pend & bus.mask;
        cand_any = |cand;
    end

    // Last assignment in scan order wins, so scan from lowest priority up.
    always_comb begin
        enc_idx = '0;
        if (LSB_PRIORITY) begin
            for (int i = 31; i >= 0; i--) begin
                if (cand[i]) enc_idx = 5'(i);
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (cand[i]) enc_idx = 5'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q <= nxt_pend;
            case (state)
                IDLE: begin
                    if (cand_any) begin
                        state   <= PRESENT;
                        index_q <= enc_idx;
                        grant_q <= 32'h1 << enc_idx;
                        valid_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    // Without ack the presented index is frozen.
                    if (bus.ack) begin
                        if (cand_any) begin
                            index_q <= enc_idx;
                            grant_q <= 32'h1 << enc_idx;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.index       = index_q;
    assign bus.valid       = valid_q;
    assign bus.grant       = grant_q;
    assign bus.pending     = pend_q;
    assign bus.any_pending = |(pend_q & bus.mask);
endmodule

// File: tb/tb_priority_request_encoder.sv
// Bench for priority_request_encoder: both priority orders against a model.
// Ports: none (top-level testbench).
module tb_priority_request_encoder;
    logic        clock;
    logic        reset_n;
    logic [31:0] request;
    logic [31:0] mask;
    logic        flush;
    logic        ack;

    priority_request_encoder_if bus0 ();
    priority_request_encoder_if bus1 ();

    assign bus0.request = request;
    assign bus0.mask    = mask;
    assign bus0.flush   = flush;
    assign bus0.ack     = ack;
    assign bus1.request = request;
    assign bus1.mask    = mask;
    assign bus1.flush   = flush;
    assign bus1.ack     = ack;

    priority_request_encoder #(.LSB_PRIORITY(1'b1)) u_lsb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    priority_request_encoder #(.LSB_PRIORITY(1'b0)) u_msb (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a set of pending sources plus "what is on offer right now".
    bit [31:0] m_pend [2];
    bit        m_valid [2];
    int        m_index [2];
    bit        synced = 1'b0;

    function automatic int winner(bit [31:0] c, bit lsb);
        for (int k = 0; k < 32; k++) begin
            int b;
            b = lsb ? k : 31 - k;
            if (c[b]) return b;
        end
        return -1;
    endfunction

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            bit [31:0] p;
            bit        acked;
            int        w;
            if (!reset_n) begin
                m_pend[u]  = '0;
                m_valid[u] = 1'b0;
                m_index[u] = 0;
            end else if (flush) begin
                m_pend[u]  = '0;
                m_valid[u] = 1'b0;
            end else begin
                p     = m_pend[u];
                acked = m_valid[u] && ack;
                if (acked) p[m_index[u]] = 1'b0;
                p = p | request;
                if (!m_valid[u] || acked) begin
                    w = winner(p & mask, u == 0);
                    if (w >= 0) begin
                        m_valid[u] = 1'b1;
                        m_index[u] = w;
                    end else begin
                        m_valid[u] = 1'b0;
                    end
                end
                m_pend[u] = p;
            end
        end
        if (!reset_n) synced = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    function automatic logic [31:0] exp_grant(int u);
        return m_valid[u] ? (32'h1 << m_index[u]) : 32'h0;
    endfunction

    always @(negedge clock) begin
        if (synced) begin
            check("u0 index", 32'(bus0.index), 32'(m_index[0]));
            check("u0 valid", 32'(bus0.valid), 32'(m_valid[0]));
            check("u0 grant", bus0.grant, exp_grant(0));
            check("u0 pending", bus0.pending, m_pend[0]);
            check("u0 any_pending", 32'(bus0.any_pending),
                  32'(|(m_pend[0] & mask)));
            check("u1 index", 32'(bus1.index), 32'(m_index[1]));
            check("u1 valid", 32'(bus1.valid), 32'(m_valid[1]));
            check("u1 grant", bus1.grant, exp_grant(1));
            check("u1 pending", bus1.pending, m_pend[1]);
            check("u1 any_pending", 32'(bus1.any_pending),
                  32'(|(m_pend[1] & mask)));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(string name, int idx0, int idx1, bit v);
        check({name, " u0 valid"}, 32'(bus0.valid), 32'(v));
        check({name, " u1 valid"}, 32'(bus1.valid), 32'(v));
        if (v) begin
            check({name, " u0 index"}, 32'(bus0.index), 32'(idx0));
            check({name, " u1 index"}, 32'(bus1.index), 32'(idx1));
            check({name, " u0 grant"}, bus0.grant, 32'h1 << idx0);
            check({name, " u1 grant"}, bus1.grant, 32'h1 << idx1);
        end else begin
            check({name, " u0 grant"}, bus0.grant, 32'h0);
            check({name, " u1 grant"}, bus1.grant, 32'h0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        request = 32'hFFFF_FFFF;
        mask    = 32'hFFFF_FFFF;
        flush   = 1'b0;
        ack     = 1'b0;

        tick();
        tick();
        lit("reset", 0, 0, 1'b0);
        check("reset u0 index", 32'(bus0.index), 32'h0);
        check("reset u0 pending", bus0.pending, 32'h0);
        check("reset u1 pending", bus1.pending, 32'h0);
        reset_n = 1'b1;
        tick();
        lit("release", 0, 31, 1'b1);

        request = 32'h0;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;

        request = 32'h8000_0011;
        ack     = 1'b1;
        tick();
        request = 32'h0;
        lit("drain 1", 0, 31, 1'b1);
        tick();
        lit("drain 2", 4, 4, 1'b1);
        tick();
        lit("drain 3", 31, 0, 1'b1);
        tick();
        lit("drain end", 0, 0, 1'b0);
        check("drain u0 pending", bus0.pending, 32'h0);
        check("drain u1 pending", bus1.pending, 32'h0);
        ack = 1'b0;

        request = 32'h0000_0080;
        tick();
        lit("hold pres", 7, 7, 1'b1);
        request = 32'h0000_0004;
        mask    = ~32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            tick();
            request = 32'h0;
            lit("hold", 7, 7, 1'b1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        lit("hold ack", 2, 2, 1'b1);
        mask  = 32'hFFFF_FFFF;
        flush = 1'b1;
        tick();
        flush = 1'b0;

        mask    = 32'h0;
        request = 32'h0000_0100;
        tick();
        request = 32'h0;
        lit("masked", 0, 0, 1'b0);
        check("masked pending", bus0.pending, 32'h0000_0100);
        check("masked any", 32'(bus0.any_pending), 32'h0);
        mask = 32'h0000_0100;
        tick();
        lit("unmask", 8, 8, 1'b1);
        ack = 1'b1;
        tick();
        lit("unmask drain", 0, 0, 1'b0);
        mask = 32'hFFFF_FFFF;

        request = 32'h0000_0008;
        tick();
        lit("soc first", 3, 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("soc", 3, 3, 1'b1);
            check("soc pending3", 32'(bus0.pending[3]), 32'h1);
        end
        request = 32'h0;
        tick();
        lit("soc drop", 0, 0, 1'b0);
        ack = 1'b0;

        request = 32'h0000_F000;
        tick();
        request = 32'h0;
        lit("pre flush", 12, 15, 1'b1);
        flush   = 1'b1;
        ack     = 1'b1;
        request = 32'h0000_0002;
        tick();
        flush   = 1'b0;
        ack     = 1'b0;
        request = 32'h0;
        lit("flush", 0, 0, 1'b0);
        check("flush pending", bus0.pending, 32'h0);

        request = 32'h0000_F000;
        tick();
        request = 32'h0;
        lit("pre reset", 12, 15, 1'b1);
        reset_n = 1'b0;
        ack     = 1'b1;
        request = 32'h0000_0002;
        tick();
        reset_n = 1'b1;
        ack     = 1'b0;
        request = 32'h0;
        lit("mid reset", 0, 0, 1'b0);
        check("mid reset pending", bus0.pending, 32'h0);
        check("mid reset index", 32'(bus0.index), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            request = ($urandom_range(0, 3) == 0)
                    ? ($urandom & $urandom & $urandom) : 32'h0;
            mask    = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            ack     = 1'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 40) == 0);
            reset_n = ($urandom_range(0, 150) != 0);
            tick();
        end
        reset_n = 1'b1;
        flush   = 1'b0;
        ack     = 1'b0;
        request = 32'h0;
        tick();
        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
